// File: rtl/sdram_word_bridge_pkg.sv
// Shared types and widths for the 32-bit word to 16-bit SDRAM bridge.
package sdram_word_bridge_pkg;

    localparam int SDRAM_AW = 23;
    localparam int HALF_W   = 16;
    localparam int WORD_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        LO_WAIT,
        LO_REQ,
        HI_WAIT,
        HI_REQ,
        RESP
    } state_t;

endpackage

// File: rtl/sdram_half_xfer.sv
// One strobe/done SDRAM access with a watchdog that aborts a hung device.
module sdram_half_xfer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_l,
    input  logic active,
    input  logic done,
    output logic fire,
    output logic abort
);

    localparam int CW = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    // Idle cycles between halves clear the count for the next access.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt <= '0;
        end else if (!active) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Completion takes priority over a coincident timeout.
    assign fire  = active & done;
    assign abort = active & ~done & (cnt == LIMIT);

endmodule

// File: rtl/sdram_word_bridge.sv
// Splits a 32-bit client access into two sequential 16-bit SDRAM accesses,
// low halfword at the even address, and returns a single response.
module sdram_word_bridge
    import sdram_word_bridge_pkg::*;
#(
    parameter int WADDR_W = 22,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [WADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0]  req_wdata,
    output logic               resp_valid,
    output logic [WORD_W-1:0]  resp_rdata,
    output logic               resp_err,
    input  logic               SDRAM_ready,
    output logic               SDRAM_as,
    output logic               SDRAM_rw,
    output logic [WADDR_W:0]   SDRAM_addr,
    output logic [HALF_W-1:0]  SDRAM_data_write,
    input  logic [HALF_W-1:0]  SDRAM_data_read,
    input  logic               SDRAM_done
);

    state_t state;
    state_t nxt;

    logic               we_q;
    logic [WADDR_W-1:0] addr_q;
    logic [WORD_W-1:0]  wdata_q;
    logic [WORD_W-1:0]  rdata_q;
    logic               err_q;
    logic               active;
    logic               hi;
    logic               fire;
    logic               abort;

    sdram_half_xfer #(
        .TIMEOUT(TIMEOUT)
    ) u_xfer (
        .clk   (clk),
        .rst_l (rst_l),
        .active(active),
        .done  (SDRAM_done),
        .fire  (fire),
        .abort (abort)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // A half may only start once the device has dropped done from the last one.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (req_valid) nxt = LO_WAIT;
            LO_WAIT: if (SDRAM_ready && !SDRAM_done) nxt = LO_REQ;
            LO_REQ: begin
                if (fire) begin
                    nxt = HI_WAIT;
                end else if (abort) begin
                    nxt = RESP;
                end
            end
            HI_WAIT: if (SDRAM_ready && !SDRAM_done) nxt = HI_REQ;
            HI_REQ:  if (fire || abort) nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= 1'b0;
            end
            if (fire && !we_q) begin
                if (hi) begin
                    rdata_q[WORD_W-1:HALF_W] <= SDRAM_data_read;
                end else begin
                    rdata_q[HALF_W-1:0] <= SDRAM_data_read;
                end
            end
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign active = (state == LO_REQ) || (state == HI_REQ);
    assign hi     = (state == HI_REQ);

    assign req_ready        = (state == IDLE);
    assign resp_valid       = (state == RESP);
    assign resp_rdata       = rdata_q;
    assign resp_err         = err_q & resp_valid;
    assign SDRAM_as         = active;
    assign SDRAM_rw         = we_q;
    assign SDRAM_addr       = {addr_q, hi};
    assign SDRAM_data_write = hi ? wdata_q[WORD_W-1:HALF_W]
                                 : wdata_q[HALF_W-1:0];

endmodule

// File: tb/tb_sdram_word_bridge.sv
// Bench for sdram_word_bridge: behavioural SDRAM lane plus response and
// halfword-access scoreboards.
module tb_sdram_word_bridge;

    localparam int L = 11;

    typedef struct {
        logic        we;
        logic [21:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } resp_t;

    typedef struct {
        logic [22:0] addr;
        logic        rw;
        logic [15:0] data;
    } half_t;

    logic        clk;
    logic        rst_l;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [21:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        sdram_ready;
    logic        sdram_as;
    logic        sdram_rw;
    logic [22:0] sdram_addr;
    logic [15:0] sdram_wdata;
    logic [15:0] sdram_rdata;
    logic        sdram_done;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int t_acc = 0;
    int as_rises = 0;
    logic as_prev = 1'b0;
    logic prev_resp = 1'b0;
    logic hang = 1'b0;
    int dev_cnt = 0;

    resp_t resp_q[$];
    half_t half_q[$];
    half_t cur;
    logic [15:0] mem [logic [22:0]];

    sdram_word_bridge #(
        .WADDR_W(22),
        .TIMEOUT(16)
    ) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .SDRAM_ready     (sdram_ready),
        .SDRAM_as        (sdram_as),
        .SDRAM_rw        (sdram_rw),
        .SDRAM_addr      (sdram_addr),
        .SDRAM_data_write(sdram_wdata),
        .SDRAM_data_read (sdram_rdata),
        .SDRAM_done      (sdram_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] memget(input logic [22:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    // Device: done rises after L strobed cycles, cleared once strobe drops.
    always @(posedge clk) begin
        if (!sdram_as) begin
            dev_cnt    <= 0;
            sdram_done <= 1'b0;
        end else if (!sdram_done && !hang) begin
            dev_cnt <= dev_cnt + 1;
            if (dev_cnt == L - 1) begin
                sdram_done <= 1'b1;
                if (sdram_rw) begin
                    mem[sdram_addr] = sdram_wdata;
                end else begin
                    sdram_rdata <= memget(sdram_addr);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (prev_resp) chk("ready_after_resp", 32'(req_ready), 32'd1);
        prev_resp = resp_valid;
        if (resp_valid) begin
            chk("resp_expected", 32'(resp_q.size() != 0), 32'd1);
            if (resp_q.size() != 0) begin
                resp_t r;
                r = resp_q.pop_front();
                chk("resp_err", 32'(resp_err), 32'(r.err));
                if (!r.we && !r.err) chk("resp_rdata", resp_rdata, r.rdata);
                if (r.lat != 0) chk("latency", 32'(cyc - t_acc), 32'(r.lat));
            end
        end
        if (sdram_as && !as_prev) begin
            as_rises++;
            chk("half_expected", 32'(half_q.size() != 0), 32'd1);
            if (half_q.size() != 0) begin
                cur = half_q.pop_front();
                chk("half_addr", 32'(sdram_addr), 32'(cur.addr));
                chk("half_rw", 32'(sdram_rw), 32'(cur.rw));
                chk("half_wdata", 32'(sdram_wdata), 32'(cur.data));
            end
        end else if (sdram_as) begin
            chk("addr_stable", 32'(sdram_addr), 32'(cur.addr));
            chk("wdata_stable", 32'(sdram_wdata), 32'(cur.data));
        end
        as_prev = sdram_as;
    end

    task automatic issue(input logic we, input logic [21:0] a,
                         input logic [31:0] d, input logic [31:0] exp,
                         input logic err, input int nh, input int lat,
                         input logic hold);
        resp_t r;
        half_t h;
        @(negedge clk);
        for (int i = 0; i < 400 && !req_ready; i++) @(negedge clk);
        chk("req_ready_seen", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        r.we = we; r.rdata = exp; r.err = err; r.lat = lat;
        resp_q.push_back(r);
        h.addr = {a, 1'b0}; h.rw = we; h.data = d[15:0];
        half_q.push_back(h);
        if (nh == 2) begin
            h.addr = {a, 1'b1}; h.data = d[31:16];
            half_q.push_back(h);
        end
        @(posedge clk);
        #1;
        t_acc = cyc;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && resp_q.size() != 0; i++) @(negedge clk);
        chk("resp_drained", 32'(resp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t  vecs[8];
        resp_t r;
        half_t h;
        int    r0;
        int    n;

        rst_l = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; sdram_ready = 1'b1;
        sdram_rdata = '0; sdram_done = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_as", 32'(sdram_as), 32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;

        vecs[0] = '{1'b1, 22'h000005, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 22'h000005, 32'h0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 22'h3FFFFF, 32'h12345678, 32'h0};
        vecs[3] = '{1'b1, 22'h000000, 32'hCAFEF00D, 32'h0};
        vecs[4] = '{1'b0, 22'h3FFFFF, 32'h0, 32'h12345678};
        vecs[5] = '{1'b0, 22'h000000, 32'h0, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 22'h0000A5, 32'hA5A55A5A, 32'h0};
        vecs[7] = '{1'b0, 22'h0000A5, 32'h0, 32'hA5A55A5A};
        for (int i = 0; i < 8; i++) begin
            r0 = as_rises;
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                  1'b0, 2, 2 * L + 5, 1'b0);
            wait_drain();
            chk("as_periods", 32'(as_rises - r0), 32'd2);
        end
        chk("mem_00A", 32'(memget(23'h00000A)), 32'h0000BEEF);
        chk("mem_00B", 32'(memget(23'h00000B)), 32'h0000DEAD);
        chk("mem_top_lo", 32'(memget(23'h7FFFFE)), 32'h00005678);
        chk("mem_top_hi", 32'(memget(23'h7FFFFF)), 32'h00001234);

        // Lane not granted for 20 cycles after accept.
        sdram_ready = 1'b0;
        issue(1'b1, 22'h000111, 32'h0BADCAFE, 32'h0, 1'b0, 2, 0, 1'b0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (sdram_as) n++;
        end
        chk("as_while_unready", 32'(n), 32'd0);
        sdram_ready = 1'b1;
        wait_drain();
        issue(1'b0, 22'h000111, 32'h0, 32'h0BADCAFE, 1'b0, 2, 2 * L + 5, 1'b0);
        wait_drain();

        // Hung device: watchdog fires in the low half.
        hang = 1'b1;
        r0 = as_rises;
        issue(1'b0, 22'h000077, 32'h0, 32'h0, 1'b1, 1, 18, 1'b0);
        wait_drain();
        hang = 1'b0;
        repeat (5) @(negedge clk);
        chk("timeout_as_periods", 32'(as_rises - r0), 32'd1);

        // Reset in the middle of the high half.
        issue(1'b1, 22'h000123, 32'h11112222, 32'h0, 1'b0, 2, 0, 1'b0);
        for (int i = 0; i < 100 && !(sdram_as && sdram_addr[0]); i++)
            @(negedge clk);
        chk("reached_hi_req", 32'(sdram_as && sdram_addr[0]), 32'd1);
        #2 rst_l = 1'b0;
        #1;
        chk("mid_rst_as", 32'(sdram_as), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_addr", 32'(sdram_addr), 32'd0);
        chk("mid_rst_rw", 32'(sdram_rw), 32'd0);
        chk("mid_rst_wdata", 32'(sdram_wdata), 32'd0);
        chk("mid_rst_rdata", resp_rdata, 32'd0);
        if (resp_q.size() != 0) r = resp_q.pop_back();
        @(negedge clk);
        #2 rst_l = 1'b1;
        repeat (30) @(negedge clk);
        chk("halves_after_rst", 32'(half_q.size()), 32'd0);
        issue(1'b0, 22'h000005, 32'h0, 32'hDEADBEEF, 1'b0, 2, 2 * L + 5, 1'b0);
        wait_drain();

        // Back-to-back reads with req_valid held high.
        @(negedge clk);
        for (int i = 0; i < 400 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0;
        req_addr = 22'h3FFFFF; req_wdata = '0;
        r.we = 1'b0; r.err = 1'b0; r.lat = 0;
        r.rdata = 32'h12345678;
        resp_q.push_back(r);
        h.rw = 1'b0; h.data = 16'h0;
        h.addr = 23'h7FFFFE; half_q.push_back(h);
        h.addr = 23'h7FFFFF; half_q.push_back(h);
        @(posedge clk);
        #1;
        req_addr = 22'h000000;
        r.rdata = 32'hCAFEF00D;
        resp_q.push_back(r);
        h.addr = 23'h000000; half_q.push_back(h);
        h.addr = 23'h000001; half_q.push_back(h);
        @(negedge clk);
        for (int i = 0; i < 400 && !req_ready; i++) @(negedge clk);
        chk("b2b_second_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        chk("halves_consumed", 32'(half_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sdram_word_bridge.md
Name: sdram_word_bridge

Overview:
- Sits directly upstream of the memory-port arbiter's SDRAM lane, on the port side.
- Accepts one 32-bit word read or write from a client.
- Splits it into two sequential 16-bit SDRAM accesses on the shared SDRAM_as/rw/addr/data/done handshake, then returns one 32-bit response.
- Lowest halfword goes to the even SDRAM address. A watchdog aborts hung accesses.

Parameters:
- WADDR_W, 22, client word-address width; SDRAM address width = WADDR_W+1.
- TIMEOUT, 255, max cycles SDRAM_as may stay high without SDRAM_done before the access is aborted.

Ports:
- clk  input  1  system clock
- rst_l  input  1  reset; asynchronous, active-low
- req_valid  input  1  client request present
- req_ready  output  1  bridge can accept a request
- req_we  input  1  1=write, 0=read
- req_addr  input  WADDR_W  word address
- req_wdata  input  32  write data
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  read data; valid with resp_valid when read
- resp_err  output  1  timeout flag; valid with resp_valid
- SDRAM_ready  input  1  lane granted to this port
- SDRAM_as  output  1  access strobe
- SDRAM_rw  output  1  1=write, 0=read
- SDRAM_addr  output  WADDR_W+1  halfword address
- SDRAM_data_write  output  16  halfword write data
- SDRAM_data_read  input  16  halfword read data; valid when SDRAM_done=1
- SDRAM_done  input  1  level; high once access complete, cleared by device after SDRAM_as drops

Behaviour:
- Reset (async, any state, including mid-access): state=IDLE, all outputs 0 except req_ready=1, watchdog=0, internal lo/hi registers 0. An aborted in-flight request produces no response.
- States:
  - IDLE: req_ready=1. On req_valid, latch we/addr/wdata and go to LO_WAIT.
  - LO_WAIT: wait for SDRAM_ready=1 and SDRAM_done=0, then go to LO_REQ.
  - LO_REQ: SDRAM_as=1, SDRAM_addr={addr,1'b0}, data=wdata[15:0], rw=we. Outputs are held stable for the whole state.
    - SDRAM_done=1: capture SDRAM_data_read into rdata[15:0] (reads only), go to HI_WAIT.
    - Watchdog reaches TIMEOUT first: go to RESP with err=1.
  - HI_WAIT: SDRAM_as=0. Wait for SDRAM_done=0 and SDRAM_ready=1, then go to HI_REQ.
  - HI_REQ: as LO_REQ but addr={addr,1'b1}, data=wdata[31:16], capture into rdata[31:16]. On done go to RESP with err=0; on timeout go to RESP with err=1.
  - RESP: resp_valid=1 for exactly one cycle, SDRAM_as=0, then IDLE.
- req_ready=1 only in IDLE, so a new request can be accepted no earlier than the cycle after RESP.
- Watchdog:
  - 8+ bit counter, cleared on entry to LO_REQ/HI_REQ, increments each cycle in those states.
  - Abort when counter==TIMEOUT and SDRAM_done=0.
  - If done and the timeout condition coincide, done wins.
- SDRAM_as drops for at least one cycle between halves, so the device clears SDRAM_done. SDRAM_ready may be lost during the gap; the bridge simply waits.
- SDRAM_ready dropping while in LO_REQ/HI_REQ is ignored: strobe held until done or timeout.
- resp_rdata holds its last value until the next read completes. On a write or an error, resp_rdata is unspecified but stable.
- Address: SDRAM_addr = req_addr*2 + half. Arithmetic is a concatenation; no carry or wrap concerns. Max address 2^WADDR_W-1 maps to halfwords 2^(WADDR_W+1)-2 and -1.
- Minimum latency with ready=1 and a device latency of L cycles per access: accept→resp_valid = 2L + 5 cycles.

Decomposition:
- Shared mem package: state enum (IDLE, LO_WAIT, LO_REQ, HI_WAIT, HI_REQ, RESP), SDRAM_AW=23, HALF_W=16, WORD_W=32.
- One natural sub-module: sdram_half_xfer, a single strobe/done access with watchdog, instantiated once and sequenced twice by the top FSM. A flat FSM is also acceptable.

Test Plan:
- Write: req_addr=0x000005, wdata=0xDEADBEEF, behavioural SDRAM with 11-cycle latency → halfword 0x00A=0xBEEF, halfword 0x00B=0xDEAD. One resp_valid with err=0, exactly two SDRAM_as high periods.
- Readback of the same address → resp_rdata=0xDEADBEEF, err=0, accept-to-resp = 27 cycles.
- SDRAM_ready held 0 for 20 cycles after accept, then 1 → SDRAM_as stays 0 for those 20 cycles. The access then completes correctly with no spurious resp_valid.
- Device never asserts done, TIMEOUT=16 → resp_valid with err=1 after the watchdog expires in LO_REQ. No HI access is issued; req_ready returns to 1 on the following cycle.
- rst_l pulsed low during HI_REQ → outputs go to reset values immediately. No resp_valid; the next request completes normally.
- Back-to-back: req_valid held high with addresses 0x3FFFFF then 0x000000 → SDRAM_addr sequence 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001. Two responses in order.
